ysyx_23060077_lsu: RTL and testbench
====================================

Name: ysyx_23060077_lsu

Overview:
- Load/store stage directly downstream of the EX-stage ALU.
- Takes the ALU result as the effective address (or as a pass-through result for non-memory ops) plus the store data. Issues one memory transaction over a valid/ready request and valid response bus.
- Aligns, masks and sign-extends load data, then hands a single result beat to write-back.
- One instruction in flight at a time; the upstream stage stalls through `ex_ready`.

Parameters:
- DATA_WIDTH, 64, datapath and address width.
- STRB_WIDTH, DATA_WIDTH/8, memory byte-enable width.

Ports:
- clock  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ex_valid  in  1  EX holds a valid instruction
- ex_ready  out  1  LSU accepts the EX beat this cycle
- ex_alu_out  in  DATA_WIDTH  ALU result: effective address, or final result for non-memory ops
- ex_store_data  in  DATA_WIDTH  rs2 value for stores
- ex_is_load  in  1  instruction is a load
- ex_is_store  in  1  instruction is a store
- ex_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- ex_rd  in  5  destination register
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  DATA_WIDTH  address, aligned down to 8 bytes
- mem_req_wen  out  1  1 = write
- mem_req_wdata  out  DATA_WIDTH  store data shifted into byte lane
- mem_req_wstrb  out  STRB_WIDTH  byte enables (0 for reads)
- mem_resp_valid  in  1  response beat
- mem_resp_rdata  in  DATA_WIDTH  read data, full aligned doubleword
- mem_resp_err  in  1  bus error on this response
- wb_valid  out  1  result valid to write-back
- wb_ready  in  1  write-back accepts
- wb_data  out  DATA_WIDTH  load result or pass-through ALU result
- wb_rd  out  5  destination register
- wb_err  out  1  misaligned access or bus error

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE.
  - mem_req_valid, wb_valid and wb_err = 0.
  - wb_data, wb_rd, mem_req_addr, mem_req_wdata and mem_req_wstrb = 0.
  - Reset mid-transaction abandons it. A later stray mem_resp_valid arriving in IDLE is ignored.
- ex_ready = (state == IDLE). The EX beat is captured on `ex_valid & ex_ready`, latching all ex_* inputs.
- Misalignment check on the captured beat:
  - h: addr[0] != 0.
  - w/wu: addr[1:0] != 0.
  - d: addr[2:0] != 0.
  - b/bu: never misaligned.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE -> DONE when the accepted beat is a non-memory op. wb_data = ex_alu_out, wb_err = 0. Latency is 1 cycle.
  - IDLE -> DONE when the accepted beat is a load or store and misaligned. wb_err = 1, wb_data = 0, no memory request is issued.
  - IDLE -> REQ otherwise. mem_req_valid asserts the cycle after accept.
  - REQ: mem_req_valid = 1 and the request fields stay stable until mem_req_ready. On `mem_req_valid & mem_req_ready` go to WAIT. mem_resp_valid seen in REQ is ignored.
  - WAIT: on mem_resp_valid, capture the result and go to DONE.
    - Load: wb_data = extended lane of mem_resp_rdata.
    - Store: wb_data = 0.
    - wb_err = mem_resp_err.
  - DONE: wb_valid = 1, outputs held stable until wb_ready, then go to IDLE. The next ex beat can be accepted in the cycle after the wb handshake, not the same cycle.
- Request encoding:
  - Lane offset = addr[2:0].
  - mem_req_wdata = store data << (8*offset).
  - mem_req_wstrb = size mask << offset, where size mask is b 0x01, h 0x03, w 0x0F, d 0xFF.
  - mem_req_wen = is_store.
- Load extraction:
  - Shift rdata right by 8*offset, then mask to the access size.
  - b/h/w sign-extend from the top bit of the size.
  - bu/hu/wu zero-extend.
  - d passes through unchanged.
- funct3 = 111 on a memory op is treated as misaligned, so wb_err = 1.
- ex_is_load and ex_is_store both set is illegal. Store wins.
- Minimum latency:
  - Non-memory op: 1 cycle to wb_valid.
  - Memory op: accept, REQ, WAIT, then DONE, i.e. 3 cycles when ready and response are immediate.

Test Plan:
- Pass-through: ex non-memory op with alu_out=0x1234 and wb_ready held at 1 -> wb_valid exactly one cycle after accept, wb_data=0x1234, no mem_req_valid, ex_ready high again the next cycle.
- lb sign extension: addr=0x8000_0003, rdata=0x0000_0000_80FF_0000 -> req addr 0x8000_0000, wstrb=0, wen=0. Byte 3 = 0x80 -> wb_data=0xFFFF_FFFF_FFFF_FF80. The same case with lbu -> 0x80.
- sh lane shift: addr=0x1006, store_data=0xABCD, mem_req_ready held low 3 cycles -> wdata=0xABCD_0000_0000_0000, wstrb=0xC0, all fields stable while stalled. Response -> wb_data=0, wb_err=0.
- Misaligned lw: addr=0x1002 -> no memory request, wb_valid one cycle after accept, wb_err=1.
- Bus error and backpressure: ld with mem_resp_err=1 and wb_ready low 2 cycles -> wb_valid, wb_err=1 and wb_rd held stable. ex_ready stays low until the cycle after the wb handshake.
- Reset mid-op: rst_n low while in WAIT, then a late mem_resp_valid -> outputs at reset values, response ignored, the next ld completes normally.

Source files
------------

// File: rtl/ysyx_23060077_lsu.sv
// Load/store unit: accepts one EX beat at a time, issues at most one memory
// transaction, then aligns/extends load data into a single write-back beat.
module ysyx_23060077_lsu #(
    parameter int DATA_WIDTH = 64,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clock,
    input  logic                  rst_n,

    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [DATA_WIDTH-1:0] ex_alu_out,
    input  logic [DATA_WIDTH-1:0] ex_store_data,
    input  logic                  ex_is_load,
    input  logic                  ex_is_store,
    input  logic [2:0]            ex_funct3,
    input  logic [4:0]            ex_rd,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    output logic                  mem_req_wen,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [STRB_WIDTH-1:0] mem_req_wstrb,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    input  logic                  mem_resp_err,

    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [4:0]            wb_rd,
    output logic                  wb_err
);
    localparam int OFF_W = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t                state_q, state_d;
    logic                  req_valid_q, req_valid_d;
    logic [DATA_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  req_wen_q, req_wen_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic [STRB_WIDTH-1:0] req_wstrb_q, req_wstrb_d;
    logic                  wb_valid_q, wb_valid_d;
    logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]            wb_rd_q, wb_rd_d;
    logic                  wb_err_q, wb_err_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  is_load_q, is_load_d;

    logic                  accept;
    logic                  ex_is_mem;
    logic                  ex_misaligned;
    logic [OFF_W-1:0]      ex_off;
    logic [STRB_WIDTH-1:0] ex_size_mask;
    logic [DATA_WIDTH-1:0] lane;
    logic [DATA_WIDTH-1:0] load_ext;

    assign ex_ready  = (state_q == IDLE);
    assign accept    = ex_valid & ex_ready;
    assign ex_is_mem = ex_is_load | ex_is_store;
    assign ex_off    = ex_alu_out[OFF_W-1:0];

    // funct3 = 111 has no defined access size, so it is rejected like a misaligned access
    always_comb begin
        ex_misaligned = 1'b0;
        case (ex_funct3)
            3'b001, 3'b101: ex_misaligned = ex_alu_out[0];
            3'b010, 3'b110: ex_misaligned = |ex_alu_out[1:0];
            3'b011:         ex_misaligned = |ex_alu_out[2:0];
            3'b111:         ex_misaligned = 1'b1;
            default:        ex_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        ex_size_mask = '0;
        case (ex_funct3[1:0])
            2'b00:   ex_size_mask = STRB_WIDTH'(8'h01);
            2'b01:   ex_size_mask = STRB_WIDTH'(8'h03);
            2'b10:   ex_size_mask = STRB_WIDTH'(8'h0F);
            default: ex_size_mask = STRB_WIDTH'(8'hFF);
        endcase
    end

    assign lane = mem_resp_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = lane;
        case (funct3_q)
            3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
            3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            3'b010:  load_ext = {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
            3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
            3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}}, lane[31:0]};
            default: load_ext = lane;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_addr_d  = req_addr_q;
        req_wen_d   = req_wen_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_err_d    = wb_err_q;
        off_d       = off_q;
        funct3_d    = funct3_q;
        is_load_d   = is_load_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    wb_rd_d   = ex_rd;
                    off_d     = ex_off;
                    funct3_d  = ex_funct3;
                    is_load_d = ex_is_load & ~ex_is_store;
                    if (!ex_is_mem) begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_out;
                        wb_err_d   = 1'b0;
                    end else if (ex_misaligned) begin
                        state_d    = DONE;
                        wb_valid_d = 1'b1;
                        wb_data_d  = '0;
                        wb_err_d   = 1'b1;
                    end else begin
                        state_d     = REQ;
                        req_valid_d = 1'b1;
                        req_addr_d  = {ex_alu_out[DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        req_wen_d   = ex_is_store;
                        req_wdata_d = ex_store_data << {ex_off, 3'b000};
                        req_wstrb_d = ex_is_store ? (ex_size_mask << ex_off) : '0;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    state_d    = DONE;
                    wb_valid_d = 1'b1;
                    wb_err_d   = mem_resp_err;
                    wb_data_d  = is_load_q ? load_ext : '0;
                end
            end
            DONE: begin
                if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            req_wen_q   <= 1'b0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_err_q    <= 1'b0;
            off_q       <= '0;
            funct3_q    <= '0;
            is_load_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_addr_q  <= req_addr_d;
            req_wen_q   <= req_wen_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_err_q    <= wb_err_d;
            off_q       <= off_d;
            funct3_q    <= funct3_d;
            is_load_q   <= is_load_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_wen   = req_wen_q;
    assign mem_req_wdata = req_wdata_q;
    assign mem_req_wstrb = req_wstrb_q;
    assign wb_valid      = wb_valid_q;
    assign wb_data       = wb_data_q;
    assign wb_rd         = wb_rd_q;
    assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_ysyx_23060077_lsu.sv
// Bench for ysyx_23060077_lsu: directed vector table, reset corner cases and
// randomized operations checked against a behavioural model.
module tb_ysyx_23060077_lsu;
    logic        clock = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_alu_out;
    logic [63:0] ex_store_data;
    logic        ex_is_load;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_req_wen;
    logic [63:0] mem_req_wdata;
    logic [7:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        mem_resp_err;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_err;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    ysyx_23060077_lsu #(.DATA_WIDTH(64)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_out     (ex_alu_out),
        .ex_store_data  (ex_store_data),
        .ex_is_load     (ex_is_load),
        .ex_is_store    (ex_is_store),
        .ex_funct3      (ex_funct3),
        .ex_rd          (ex_rd),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wen    (mem_req_wen),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wstrb  (mem_req_wstrb),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata),
        .mem_resp_err   (mem_resp_err),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_data        (wb_data),
        .wb_rd          (wb_rd),
        .wb_err         (wb_err)
    );

    typedef struct {
        logic [63:0] alu;
        logic [63:0] sdata;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        err;
        int          rs;
        int          rdly;
        int          ws;
    } op_t;

    typedef struct {
        logic        saw_req;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] wb_data;
        logic        wb_err;
        int          lat;
    } exp_t;

    typedef struct {
        op_t  op;
        exp_t exp;
    } vec_t;

    typedef struct {
        logic        saw_req;
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic [63:0] wb_data;
        logic        wb_err;
        logic [4:0]  wb_rd;
        int          lat;
        logic        req_stable;
        logic        wb_stable;
        logic        busy_ok;
        logic        ready_after;
        logic        wb_after;
        logic        timeout;
    } obs_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic [63:0] alu, input logic [63:0] sdata, input logic ld, input logic st,
        input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] rdata, input logic err,
        input int rs, input int rdly, input int ws,
        input logic saw, input logic [63:0] addr, input logic wen, input logic [63:0] wdata,
        input logic [7:0] wstrb, input logic [63:0] wbd, input logic wbe, input int lat);
        vec_t v;
        v.op  = '{alu, sdata, ld, st, f3, rd, rdata, err, rs, rdly, ws};
        v.exp = '{saw, addr, wen, wdata, wstrb, wbd, wbe, lat};
        return v;
    endfunction

    // Reference behaviour expressed as byte arithmetic on the access size and offset
    function automatic exp_t model(input op_t op);
        exp_t        e;
        int          size;
        int          off;
        int          bits;
        logic [63:0] v;
        logic [63:0] mask;
        logic [15:0] strb;
        e = '{1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 64'd0, 1'b0, 0};
        if (!(op.ld || op.st)) begin
            e.wb_data = op.alu;
            e.lat     = 1;
            return e;
        end
        size = 1 << op.f3[1:0];
        if (op.f3 == 3'b111 || (op.alu % 64'(size)) != 64'd0) begin
            e.wb_err = 1'b1;
            e.lat    = 1;
            return e;
        end
        off       = int'(op.alu % 64'd8);
        e.saw_req = 1'b1;
        e.addr    = op.alu - 64'(off);
        e.wen     = op.st;
        e.wdata   = op.sdata << (8 * off);
        strb      = op.st ? 16'(((1 << size) - 1) << off) : 16'd0;
        e.wstrb   = strb[7:0];
        e.wb_err  = op.err;
        e.lat     = 3 + op.rs + op.rdly;
        if (op.ld && !op.st) begin
            bits = 8 * size;
            v    = op.rdata >> (8 * off);
            if (bits < 64) begin
                mask = (64'd1 << bits) - 64'd1;
                v    = v & mask;
                if (!op.f3[2] && v[bits-1]) v = v | ~mask;
            end
            e.wb_data = v;
        end
        return e;
    endfunction

    // Drives one instruction through the DUT and plays the memory and WB sides
    task automatic applyStimulus(input op_t op, output obs_t o);
        int   cyc;
        int   rsc;
        int   rdc;
        int   wsc;
        int   k;
        logic req_hs;
        logic resp_sent;
        logic seen_wb;
        logic done;
        o = '{1'b0, 64'd0, 1'b0, 64'd0, 8'd0, 64'd0, 1'b0, 5'd0, 0,
              1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        k = 0;
        while (!ex_ready && k < 20) begin
            @(posedge clock); @(negedge clock);
            k++;
        end
        ex_valid      = 1'b1;
        ex_alu_out    = op.alu;
        ex_store_data = op.sdata;
        ex_is_load    = op.ld;
        ex_is_store   = op.st;
        ex_funct3     = op.f3;
        ex_rd         = op.rd;
        @(posedge clock); @(negedge clock);
        ex_valid      = 1'b0;
        ex_alu_out    = {$urandom, $urandom};
        ex_store_data = {$urandom, $urandom};
        ex_is_load    = 1'($urandom);
        ex_is_store   = 1'($urandom);
        ex_funct3     = 3'($urandom);
        ex_rd         = 5'($urandom);
        cyc = 1; rsc = 0; rdc = 0; wsc = 0;
        req_hs = 1'b0; resp_sent = 1'b0; seen_wb = 1'b0; done = 1'b0;
        while (!done && cyc < 100) begin
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            mem_resp_rdata = {$urandom, $urandom};
            wb_ready       = 1'b0;
            if (ex_ready) o.busy_ok = 1'b0;
            if (mem_req_valid) begin
                if (!o.saw_req) begin
                    o.saw_req = 1'b1;
                    o.addr    = mem_req_addr;
                    o.wen     = mem_req_wen;
                    o.wdata   = mem_req_wdata;
                    o.wstrb   = mem_req_wstrb;
                end else if (mem_req_addr !== o.addr || mem_req_wen !== o.wen ||
                             mem_req_wdata !== o.wdata || mem_req_wstrb !== o.wstrb) begin
                    o.req_stable = 1'b0;
                end
                if (rsc == op.rs) begin
                    mem_req_ready = 1'b1;
                    req_hs        = 1'b1;
                end else begin
                    rsc++;
                    mem_resp_valid = 1'b1;
                    mem_resp_err   = 1'b1;
                end
            end else if (req_hs && !resp_sent) begin
                if (rdc == op.rdly) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_rdata = op.rdata;
                    mem_resp_err   = op.err;
                    resp_sent      = 1'b1;
                end else begin
                    rdc++;
                end
            end
            if (wb_valid) begin
                if (!seen_wb) begin
                    seen_wb   = 1'b1;
                    o.lat     = cyc;
                    o.wb_data = wb_data;
                    o.wb_err  = wb_err;
                    o.wb_rd   = wb_rd;
                end else if (wb_data !== o.wb_data || wb_err !== o.wb_err || wb_rd !== o.wb_rd) begin
                    o.wb_stable = 1'b0;
                end
                if (wsc == op.ws) begin
                    wb_ready = 1'b1;
                    done     = 1'b1;
                end else begin
                    wsc++;
                end
            end
            @(posedge clock); @(negedge clock);
            cyc++;
        end
        o.timeout      = !done;
        wb_ready       = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        o.ready_after  = ex_ready;
        o.wb_after     = wb_valid;
    endtask

    task automatic checkOutput(input string tag, input op_t op, input exp_t e, input obs_t o);
        chk({tag, ".timeout"}, 64'(o.timeout), 64'd0);
        chk({tag, ".saw_req"}, 64'(o.saw_req), 64'(e.saw_req));
        if (e.saw_req) begin
            chk({tag, ".addr"}, o.addr, e.addr);
            chk({tag, ".wen"}, 64'(o.wen), 64'(e.wen));
            chk({tag, ".wstrb"}, 64'(o.wstrb), 64'(e.wstrb));
            chk({tag, ".req_stable"}, 64'(o.req_stable), 64'd1);
            if (e.wen) chk({tag, ".wdata"}, o.wdata, e.wdata);
        end
        chk({tag, ".wb_data"}, o.wb_data, e.wb_data);
        chk({tag, ".wb_err"}, 64'(o.wb_err), 64'(e.wb_err));
        chk({tag, ".wb_rd"}, 64'(o.wb_rd), 64'(op.rd));
        chk({tag, ".latency"}, 64'(o.lat), 64'(e.lat));
        chk({tag, ".wb_stable"}, 64'(o.wb_stable), 64'd1);
        chk({tag, ".ex_ready_busy"}, 64'(o.busy_ok), 64'd1);
        chk({tag, ".ex_ready_after"}, 64'(o.ready_after), 64'd1);
        chk({tag, ".wb_valid_after"}, 64'(o.wb_after), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".ex_ready"}, 64'(ex_ready), 64'd1);
        chk({tag, ".mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, ".wb_valid"}, 64'(wb_valid), 64'd0);
        chk({tag, ".wb_err"}, 64'(wb_err), 64'd0);
        chk({tag, ".wb_data"}, wb_data, 64'd0);
        chk({tag, ".wb_rd"}, 64'(wb_rd), 64'd0);
        chk({tag, ".mem_req_addr"}, mem_req_addr, 64'd0);
        chk({tag, ".mem_req_wdata"}, mem_req_wdata, 64'd0);
        chk({tag, ".mem_req_wstrb"}, 64'(mem_req_wstrb), 64'd0);
    endtask

    initial begin
        vec_t     vt[$];
        vec_t     v;
        obs_t     o;
        op_t      op;
        int       k;
        int       kind;

        rst_n = 1'b0;
        ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_is_load = 1'b0;
        ex_is_store = 1'b0; ex_funct3 = '0; ex_rd = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; mem_resp_err = 1'b0;
        wb_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(posedge clock); @(negedge clock);

        vt.push_back(mkv(64'h1234, 64'h0, 1'b0, 1'b0, 3'b000, 5'd5, 64'h0, 1'b0, 0, 0, 0,
                         1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h1234, 1'b0, 1));
        vt.push_back(mkv(64'h8000_0003, 64'h0, 1'b1, 1'b0, 3'b000, 5'd10, 64'h0000_0000_80FF_0000, 1'b0, 0, 0, 0,
                         1'b1, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3));
        vt.push_back(mkv(64'h8000_0003, 64'h0, 1'b1, 1'b0, 3'b100, 5'd10, 64'h0000_0000_80FF_0000, 1'b0, 0, 0, 0,
                         1'b1, 64'h8000_0000, 1'b0, 64'h0, 8'h00, 64'h80, 1'b0, 3));
        vt.push_back(mkv(64'h1006, 64'hABCD, 1'b0, 1'b1, 3'b001, 5'd3, 64'h0, 1'b0, 3, 0, 0,
                         1'b1, 64'h1000, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0, 64'h0, 1'b0, 6));
        vt.push_back(mkv(64'h1002, 64'h0, 1'b1, 1'b0, 3'b010, 5'd7, 64'h0, 1'b0, 0, 0, 0,
                         1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 1));
        vt.push_back(mkv(64'h2000, 64'h0, 1'b1, 1'b0, 3'b011, 5'd17, 64'h1122_3344_5566_7788, 1'b1, 0, 0, 2,
                         1'b1, 64'h2000, 1'b0, 64'h0, 8'h00, 64'h1122_3344_5566_7788, 1'b1, 3));
        vt.push_back(mkv(64'h1002, 64'h0, 1'b1, 1'b0, 3'b001, 5'd8, 64'h0000_0000_8001_0000, 1'b0, 0, 1, 0,
                         1'b1, 64'h1000, 1'b0, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 4));
        vt.push_back(mkv(64'h1004, 64'h0, 1'b1, 1'b0, 3'b110, 5'd9, 64'h89AB_CDEF_0000_0000, 1'b0, 1, 0, 1,
                         1'b1, 64'h1000, 1'b0, 64'h0, 8'h00, 64'h0000_0000_89AB_CDEF, 1'b0, 4));
        vt.push_back(mkv(64'h1004, 64'h0, 1'b1, 1'b0, 3'b010, 5'd9, 64'h89AB_CDEF_0000_0000, 1'b0, 0, 0, 0,
                         1'b1, 64'h1000, 1'b0, 64'h0, 8'h00, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 3));
        vt.push_back(mkv(64'h1000, 64'h0, 1'b1, 1'b0, 3'b111, 5'd11, 64'h0, 1'b0, 0, 0, 0,
                         1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 1));
        vt.push_back(mkv(64'h1008, 64'hDEAD_BEEF_0BAD_F00D, 1'b1, 1'b1, 3'b011, 5'd12, 64'h5555, 1'b0, 0, 2, 0,
                         1'b1, 64'h1008, 1'b1, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 64'h0, 1'b0, 5));
        vt.push_back(mkv(64'h1007, 64'hFFEE, 1'b0, 1'b1, 3'b000, 5'd13, 64'h0, 1'b0, 0, 0, 0,
                         1'b1, 64'h1000, 1'b1, 64'hEE00_0000_0000_0000, 8'h80, 64'h0, 1'b0, 3));
        vt.push_back(mkv(64'h1004, 64'h0, 1'b1, 1'b0, 3'b011, 5'd14, 64'h0, 1'b0, 0, 0, 0,
                         1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1, 1));
        vt.push_back(mkv(64'hFEDC_BA98_7654_3210, 64'h0, 1'b0, 1'b0, 3'b111, 5'd15, 64'h0, 1'b0, 0, 0, 0,
                         1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'hFEDC_BA98_7654_3210, 1'b0, 1));

        foreach (vt[i]) begin
            applyStimulus(vt[i].op, o);
            checkOutput($sformatf("vec%0d", i), vt[i].op, vt[i].exp, o);
        end

        // Reset while waiting for a response, then a stray response in IDLE
        ex_valid = 1'b1; ex_alu_out = 64'h3010; ex_store_data = 64'h0;
        ex_is_load = 1'b1; ex_is_store = 1'b0; ex_funct3 = 3'b011; ex_rd = 5'd21;
        @(posedge clock); @(negedge clock);
        ex_valid = 1'b0;
        chk("rst.req_valid", 64'(mem_req_valid), 64'd1);
        mem_req_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        mem_req_ready = 1'b0;
        chk("rst.wait_ex_ready", 64'(ex_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clock); @(negedge clock);
        rst_n = 1'b1;
        mem_resp_valid = 1'b1; mem_resp_rdata = 64'hCAFE_F00D_1234_5678; mem_resp_err = 1'b1;
        @(posedge clock); @(negedge clock);
        mem_resp_valid = 1'b0; mem_resp_err = 1'b0;
        check_reset_values("rst.after_stray");
        @(posedge clock); @(negedge clock);
        chk("rst.still_idle_wb_valid", 64'(wb_valid), 64'd0);
        v = mkv(64'h3008, 64'h0, 1'b1, 1'b0, 3'b011, 5'd22, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 0, 0,
                1'b1, 64'h3008, 1'b0, 64'h0, 8'h00, 64'h0123_4567_89AB_CDEF, 1'b0, 3);
        applyStimulus(v.op, o);
        checkOutput("rst.next_ld", v.op, v.exp, o);

        for (int n = 0; n < 60; n++) begin
            kind      = int'($urandom_range(0, 3));
            op.ld     = (kind == 1) || (kind == 3);
            op.st     = (kind == 2) || (kind == 3);
            op.f3     = 3'($urandom_range(0, 7));
            op.alu    = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) op.alu[2:0] = 3'b000;
            op.sdata  = {$urandom, $urandom};
            op.rd     = 5'($urandom);
            op.rdata  = {$urandom, $urandom};
            op.err    = ($urandom_range(0, 5) == 0);
            op.rs     = int'($urandom_range(0, 2));
            op.rdly   = int'($urandom_range(0, 2));
            op.ws     = int'($urandom_range(0, 2));
            applyStimulus(op, o);
            checkOutput($sformatf("rand%0d", n), op, model(op), o);
        end

        k = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
